// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the PC fetch sequencer.
// Holds the sequencer states, the redirect kinds and the default vectors.
package pc_seq_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2,
        RD_TRAP   = 2'd3
    } redirect_kind_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

    function automatic logic is_misaligned(input logic [31:0] target);
        return target[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pcplus4.sv
// Sequential-address adder for the fetch PC.
// Wraps silently modulo 2^32.
module pc_fetch_sequencer_pcplus4 (
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and imem req/ack fetch sequencer.
// Redirects arriving while a fetch is outstanding are parked and applied on the ack.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic        misaligned,
    output logic        halted
);

    logic [1:0]     state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    redirect_kind_e pend_kind_q, pend_kind_d;
    logic [31:0]    pend_target_q, pend_target_d;
    logic           halt_pend_q, halt_pend_d;

    logic [31:0]    pc_plus4;
    redirect_kind_e in_kind;
    logic [31:0]    in_target;
    logic           in_mis;
    logic           in_accept;
    logic           pend_valid;
    logic [31:0]    sel_target;

    pc_fetch_sequencer_pcplus4 u_pcplus4 (
        .pc       (pc_q),
        .pc_plus4 (pc_plus4)
    );

    // Decode this cycle's redirect inputs; a misaligned target degrades to a trap.
    always_comb begin
        in_kind   = RD_NONE;
        in_target = pc_plus4;
        in_mis    = 1'b0;
        if (trap) begin
            in_kind   = RD_TRAP;
            in_target = TRAP_VECTOR;
        end else if (jump) begin
            in_mis    = is_misaligned(jump_target);
            in_kind   = in_mis ? RD_TRAP : RD_JUMP;
            in_target = in_mis ? TRAP_VECTOR : jump_target;
        end else if (branch_taken) begin
            in_mis    = is_misaligned(branch_target);
            in_kind   = in_mis ? RD_TRAP : RD_BRANCH;
            in_target = in_mis ? TRAP_VECTOR : branch_target;
        end else begin
            in_kind   = RD_NONE;
        end
    end

    // A parked trap can only be displaced by another trap.
    assign pend_valid = (pend_kind_q != RD_NONE);
    assign in_accept  = (in_kind != RD_NONE) &&
                        ((pend_kind_q != RD_TRAP) || (in_kind == RD_TRAP));
    assign sel_target = in_accept ? in_target : (pend_valid ? pend_target_q : pc_plus4);

    // Next-state, next-PC and pending-redirect bookkeeping.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_kind_d   = pend_kind_q;
        pend_target_d = pend_target_q;
        halt_pend_d   = halt_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (in_accept || pend_valid) begin
                    pc_d = sel_target;
                end else begin
                    pc_d = pc_q;
                end
                pend_kind_d = RD_NONE;
                if (halt || halt_pend_q) begin
                    state_d = ST_HALTED;
                end else if (!stall) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    pc_d        = sel_target;
                    pend_kind_d = RD_NONE;
                    halt_pend_d = 1'b0;
                    if (halt || halt_pend_q) begin
                        state_d = ST_HALTED;
                    end else if (stall) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    if (in_accept) begin
                        pend_kind_d   = in_kind;
                        pend_target_d = in_target;
                    end else begin
                        pend_kind_d   = pend_kind_q;
                    end
                    halt_pend_d = halt_pend_q | halt;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d     = ST_IDLE;
                pend_kind_d = RD_NONE;
                halt_pend_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            pend_kind_q   <= RD_NONE;
            pend_target_q <= RESET_VECTOR;
            halt_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
            halt_pend_q   <= halt_pend_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign halted      = (state_q == ST_HALTED);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCplus4     = pc_plus4;
    // Any redirect, new or parked, marks the returning instruction as wrong-path.
    assign instr_valid = imem_ack & imem_req & ~((in_kind != RD_NONE) | pend_valid);
    assign misaligned  = (state_q != ST_HALTED) & in_accept & in_mis;

endmodule
